// File: rtl/datapath_trace_monitor_if.sv
// Trace readout port: one record per rd_valid & rd_ready beat, oldest first.
interface datapath_trace_monitor_if #(
    parameter int DATA_W = 32,
    parameter int CYC_W  = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic              rd_we;
    logic [CYC_W-1:0]  rd_cycle;

    modport master (output rd_valid, rd_pc, rd_instr, rd_we, rd_cycle, input rd_ready);
    modport slave  (input rd_valid, rd_pc, rd_instr, rd_we, rd_cycle, output rd_ready);
endinterface

// File: rtl/datapath_trace_monitor.sv
// Ring-buffer trace of the DataPath probes with PC trigger, watchdog halt and oldest-first readout.
// Optional: define TRACE_TIMESTAMP_EN to store cycle_count with each record (else rd_cycle = 0).
module datapath_trace_monitor #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int POST       = 8,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              trig_any,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] instruction,
    input  logic              reg_write,
    output logic [1:0]        state,
    output logic              halt,
    output logic              overflow,
    output logic [CYC_W-1:0]  cycle_count,
    datapath_trace_monitor_if.master rd
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POST_W = $clog2(POST + 1);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);
    localparam logic [POST_W-1:0] POST_L = POST_W'(POST);
    localparam logic [CYC_W-1:0]  MAX_L  = CYC_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              halt_q, halt_d;
    logic              overflow_q, overflow_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [POST_W-1:0] post_q, post_d;
    logic              rd_valid_q, rd_valid_d;
    logic              halt_rise, trig, done, we_ring;

    logic [DATA_W-1:0] ring_pc [DEPTH];
    logic [DATA_W-1:0] ring_in [DEPTH];
    logic              ring_we [DEPTH];

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        rd_valid_d = rd_valid_q;
        we_ring    = 1'b0;
        done       = 1'b0;
        cycle_d    = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
        halt_rise  = (MAX_CYCLES != 0) && !halt_q && (cycle_d == MAX_L);
        halt_d     = halt_q | halt_rise;
        trig       = trig_any | (pc == trig_pc);

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    wr_ptr_d   = '0;
                end
            end
            S_ARMED, S_CAPTURE: begin
                we_ring  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != FULL)
                    count_d = count_q + 1'b1;
                else if (state_q == S_ARMED)
                    overflow_d = 1'b1;
                if (state_q == S_ARMED) begin
                    if (trig) begin
                        state_d = S_CAPTURE;
                        post_d  = POST_W'(1);
                        done    = (POST == 1);
                    end
                end else begin
                    post_d = post_q + 1'b1;
                    done   = (post_d == POST_L);
                end
                // Halt overrides any trigger decision; the current sample is already committed.
                if (done || halt_rise) begin
                    state_d    = S_READOUT;
                    rd_ptr_d   = wr_ptr_d - count_d[PTR_W-1:0];
                    rd_valid_d = (count_d != '0);
                end
            end
            S_READOUT: begin
                if (!rd_valid_q) begin
                    state_d = S_IDLE;
                end else if (rd.rd_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        rd_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Ring storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (we_ring) begin
            ring_pc[wr_ptr_q] <= pc;
            ring_in[wr_ptr_q] <= instruction;
            ring_we[wr_ptr_q] <= reg_write;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [CYC_W-1:0] ring_ts [DEPTH];
    always_ff @(posedge clock) begin
        if (we_ring) ring_ts[wr_ptr_q] <= cycle_q;
    end
    assign rd.rd_cycle = ring_ts[rd_ptr_q];
`else
    assign rd.rd_cycle = '0;
`endif

    assign rd.rd_valid  = rd_valid_q;
    assign rd.rd_pc     = ring_pc[rd_ptr_q];
    assign rd.rd_instr  = ring_in[rd_ptr_q];
    assign rd.rd_we     = ring_we[rd_ptr_q];
    assign state        = state_q;
    assign halt         = halt_q;
    assign overflow     = overflow_q;
    assign cycle_count  = cycle_q;
endmodule

// File: tb/tb_datapath_trace_monitor.sv
// Scoreboard bench: capture tasks queue expected records, monitors pop and compare on each rd beat.
module tb_datapath_trace_monitor;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [15:0] cyc;
    } rec_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, arm, trig_any, reg_write;
    logic [31:0] trig_pc, pc, instruction;
    logic [1:0]  state;
    logic        halt, overflow;
    logic [15:0] cycle_count;

    logic        wrst_n, warm, wwe;
    logic [31:0] wpc, winstr;
    logic [1:0]  wstate;
    logic        whalt, wovf;
    logic [15:0] wcyc;

    datapath_trace_monitor_if #(.DATA_W(32), .CYC_W(16)) rd_if ();
    datapath_trace_monitor_if #(.DATA_W(32), .CYC_W(16)) wd_if ();

    datapath_trace_monitor #(.DATA_W(32), .DEPTH(16), .POST(8), .CYC_W(16), .MAX_CYCLES(0)) u_dut (
        .clock(clock), .reset_n(reset_n), .arm(arm), .trig_any(trig_any), .trig_pc(trig_pc),
        .pc(pc), .instruction(instruction), .reg_write(reg_write), .state(state), .halt(halt),
        .overflow(overflow), .cycle_count(cycle_count), .rd(rd_if)
    );

    datapath_trace_monitor #(.DATA_W(32), .DEPTH(16), .POST(8), .CYC_W(16), .MAX_CYCLES(20)) u_wd (
        .clock(clock), .reset_n(wrst_n), .arm(warm), .trig_any(trig_any), .trig_pc(trig_pc),
        .pc(wpc), .instruction(winstr), .reg_write(wwe), .state(wstate), .halt(whalt),
        .overflow(wovf), .cycle_count(wcyc), .rd(wd_if)
    );

    rec_t        exp_q[$];
    rec_t        wexp_q[$];
    int          total = 0;
    int          bad = 0;
    int          stall_checks = 0;
    bit          bp_mode = 1'b0;
    int          bp_cnt = 0;
    logic [15:0] tb_cyc;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) tb_cyc <= 16'd0;
        else          tb_cyc <= tb_cyc + 16'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] p, input logic [15:0] ts);
        rec_t r;
        r.pc    = p;
        r.instr = ~p;
        r.we    = p[2];
        r.cyc   = TS_EN ? ts : 16'd0;
        return r;
    endfunction

    task automatic drive(input logic [31:0] v);
        pc = v; instruction = ~v; reg_write = v[2];
    endtask

    task automatic wdrive(input logic [31:0] v);
        wpc = v; winstr = ~v; wwe = v[2];
    endtask

    // Ready pattern: always ready, or low for 3 valid cycles then alternating.
    initial begin
        rd_if.rd_ready = 1'b1;
        wd_if.rd_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if (bp_mode) begin
                if (rd_if.rd_valid === 1'b1) bp_cnt++;
                rd_if.rd_ready = (bp_cnt > 3) ? bp_cnt[0] : 1'b0;
            end else begin
                rd_if.rd_ready = 1'b1;
            end
        end
    end

    initial begin
        rec_t e;
        rec_t held;
        bit   stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1 || rd_if.rd_valid !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    stall_checks++;
                    chk("stall_pc_instr", {rd_if.rd_pc, rd_if.rd_instr}, {held.pc, held.instr});
                    chk("stall_we_cyc", 64'({rd_if.rd_we, rd_if.rd_cycle}), 64'({held.we, held.cyc}));
                end
                if (rd_if.rd_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_record: got pc %0h, want no record", rd_if.rd_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_pc", 64'(rd_if.rd_pc), 64'(e.pc));
                        chk("rec_instr", 64'(rd_if.rd_instr), 64'(e.instr));
                        chk("rec_we", 64'(rd_if.rd_we), 64'(e.we));
                        chk("rec_cycle", 64'(rd_if.rd_cycle), 64'(e.cyc));
                    end
                end else begin
                    stalled = 1'b1;
                    held.pc = rd_if.rd_pc; held.instr = rd_if.rd_instr;
                    held.we = rd_if.rd_we; held.cyc = rd_if.rd_cycle;
                end
            end
        end
    end

    initial begin
        rec_t e;
        forever begin
            @(negedge clock);
            if (wrst_n === 1'b1 && wd_if.rd_valid === 1'b1 && wd_if.rd_ready === 1'b1) begin
                if (wexp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wd_extra_record: got pc %0h, want no record", wd_if.rd_pc);
                end else begin
                    e = wexp_q.pop_front();
                    chk("wd_rec_pc", 64'(wd_if.rd_pc), 64'(e.pc));
                    chk("wd_rec_instr", 64'(wd_if.rd_instr), 64'(e.instr));
                    chk("wd_rec_we", 64'(wd_if.rd_we), 64'(e.we));
                    chk("wd_rec_cycle", 64'(wd_if.rd_cycle), 64'(e.cyc));
                end
            end
        end
    end

    task automatic run_capture(input logic [31:0] tp, input int ta, input int n_samp,
                               input int keep_from, input logic exp_ovf);
        logic [15:0] c0;
        int t;
        @(negedge clock);
        trig_pc = tp; arm = 1'b1; drive(32'd0);
        @(posedge clock);
        @(negedge clock);
        arm = 1'b0;
        chk("armed", 64'(state), 64'd1);
        c0 = tb_cyc;
        for (int i = keep_from; i < n_samp; i++) exp_q.push_back(mk(32'(4 * i), c0 + 16'(i)));
        for (int k = 0; k < n_samp; k++) begin
            trig_any = (k == ta);
            @(posedge clock);
            @(negedge clock);
            drive(pc + 32'd4);
        end
        trig_any = 1'b0;
        chk("enter_readout", 64'(state), 64'd3);
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        t = 0;
        while ((exp_q.size() != 0 || state != 2'd0) && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("drain_in_time", 64'(t < 200), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("back_to_idle", 64'(state), 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_if.rd_valid), 64'd0);
        chk({tag, "_cycle"}, 64'(cycle_count), 64'd0);
        chk({tag, "_halt"}, 64'(halt), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, want finish within 100us");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset_n = 1'b0; wrst_n = 1'b0; arm = 1'b0; warm = 1'b0; trig_any = 1'b0;
        trig_pc = 32'hFFFF_FFF0;
        drive(32'd0); wdrive(32'd0);
        #12;
        reset_checks("por");
        @(negedge clock);
        reset_n = 1'b1;

        // pc trigger at 0x10: 4 pre + 8 post samples
        run_capture(32'h10, -1, 12, 0, 1'b0);
        // pc trigger at 0x50: 28 samples, last 16 survive
        run_capture(32'h50, -1, 28, 12, 1'b1);
        // trig_any on third sample
        run_capture(32'hFFFF_FFF0, 2, 10, 0, 1'b0);
        // back-pressure on readout
        bp_mode = 1'b1; bp_cnt = 0;
        run_capture(32'h10, -1, 12, 0, 1'b0);
        bp_mode = 1'b0;
        chk("stalls_observed", 64'(stall_checks > 0), 64'd1);
        chk("main_no_halt", 64'(halt), 64'd0);

        // async reset while in CAPTURE
        @(negedge clock);
        trig_pc = 32'h10; arm = 1'b1; drive(32'd0);
        @(posedge clock);
        @(negedge clock);
        arm = 1'b0;
        repeat (6) begin
            @(posedge clock);
            @(negedge clock);
            drive(pc + 32'd4);
        end
        chk("mid_capture", 64'(state), 64'd2);
        #2 reset_n = 1'b0;
        #1 reset_checks("mid_rst");
        @(negedge clock);
        reset_n = 1'b1;
        trig_pc = 32'hFFFF_FFF0;

        // watchdog instance: MAX_CYCLES=20, arm at cycle 2, no trigger
        @(negedge clock);
        wrst_n = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("wd_cycle2", 64'(wcyc), 64'd2);
        warm = 1'b1; wdrive(32'd0);
        @(posedge clock);
        @(negedge clock);
        warm = 1'b0;
        chk("wd_armed", 64'(wstate), 64'd1);
        for (int i = 1; i <= 16; i++) wexp_q.push_back(mk(32'(4 * i), 16'(3 + i)));
        for (int k = 0; k < 17; k++) begin
            @(posedge clock);
            @(negedge clock);
            wdrive(wpc + 32'd4);
            if (k == 15) chk("wd_no_halt_at_19", 64'({whalt, wcyc}), 64'({1'b0, 16'd19}));
        end
        chk("wd_halt", 64'(whalt), 64'd1);
        chk("wd_cycle20", 64'(wcyc), 64'd20);
        chk("wd_readout", 64'(wstate), 64'd3);
        chk("wd_overflow", 64'(wovf), 64'd1);
        t = 0;
        while ((wexp_q.size() != 0 || wstate != 2'd0) && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("wd_drain_in_time", 64'(t < 200), 64'd1);
        chk("wd_queue_empty", 64'(wexp_q.size()), 64'd0);
        chk("wd_idle", 64'(wstate), 64'd0);
        chk("wd_halt_sticky", 64'(whalt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
